// File: rtl/lru_age_eviction_engine.sv
// lru_age_eviction_engine: multi-set true-LRU age store with a victim-request handshake.
// Ages per set are a permutation of 0..NUM_WAYS-1 (0 = MRU, NUM_WAYS-1 = LRU).
// Optional feature macro: LRU_LOCK_EN adds lock_mask / rsp_none (ways excluded from eviction).
module lru_age_eviction_engine #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 64,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_busy,
    input  logic                access_valid,
    input  logic [SET_W-1:0]    access_set,
    input  logic [WAY_W-1:0]    access_way,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_W-1:0]    req_set,
    input  logic [NUM_WAYS-1:0] req_way_valid,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WAY_W-1:0]    rsp_way,
    output logic                rsp_none
`ifdef LRU_LOCK_EN
    ,
    input  logic [NUM_WAYS-1:0] lock_mask
`endif
);

    localparam int AGE_W = WAY_W;

    typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} stateT;

    stateT               state;
    stateT               stateNext;
    logic [SET_W-1:0]    initPtr;
    logic [AGE_W-1:0]    age [NUM_SETS][NUM_WAYS];
    logic [SET_W-1:0]    reqSetQ;
    logic [NUM_WAYS-1:0] reqValidQ;
    logic [NUM_WAYS-1:0] eligQ;
    logic [WAY_W-1:0]    rspWayQ;
    logic [WAY_W-1:0]    victimWay;
    logic                victimNone;
    logic                foundInvalid;
    logic [AGE_W-1:0]    bestAge;
    logic [AGE_W-1:0]    accessAge;
    logic                accept;
    logic                accessEn;
    logic                wayInRange;
    logic                setInRange;

    // Out-of-range indices are only possible when the count is not a power of two
    if ((1 << WAY_W) == NUM_WAYS) begin : gWayFull
        assign wayInRange = 1'b1;
    end else begin : gWayPart
        assign wayInRange = (access_way < WAY_W'(NUM_WAYS));
    end

    if ((1 << SET_W) == NUM_SETS) begin : gSetFull
        assign setInRange = 1'b1;
    end else begin : gSetPart
        assign setInRange = (access_set < SET_W'(NUM_SETS));
    end

    assign accept    = (state == IDLE) && req_valid;
    assign accessEn  = access_valid && wayInRange && setInRange && (state != INIT);
    assign accessAge = age[access_set][access_way];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            INIT:    if (initPtr == SET_W'(NUM_SETS - 1)) stateNext = IDLE;
            IDLE:    if (req_valid) stateNext = LOOKUP;
            LOOKUP:  stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = INIT;
        endcase
    end

    // Outputs decoded from state and the registered response
    always_comb begin
        init_busy = (state == INIT);
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_way   = rspWayQ;
    end

    // Init pointer, request capture and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            initPtr   <= '0;
            reqSetQ   <= '0;
            reqValidQ <= '0;
            rspWayQ   <= '0;
        end else begin
            if (state == INIT) initPtr <= initPtr + 1'b1;
            if (accept) begin
                reqSetQ   <= req_set;
                reqValidQ <= req_way_valid;
            end
            if (state == LOOKUP) rspWayQ <= victimWay;
        end
    end

`ifdef LRU_LOCK_EN
    logic rspNoneQ;

    // Lock mask is captured with the request; rsp_none registered in LOOKUP
    always_ff @(posedge clk) begin
        if (reset) begin
            eligQ    <= '0;
            rspNoneQ <= 1'b0;
        end else begin
            if (accept) eligQ <= ~lock_mask;
            if (state == LOOKUP) rspNoneQ <= victimNone;
        end
    end

    assign rsp_none = rspNoneQ;
`else
    assign eligQ    = '1;
    assign rsp_none = 1'b0;
`endif

    // Age array: per-set initialisation during INIT, LRU promotion on access otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    age[initPtr][w] <= AGE_W'(w);
                end
            end else if (accessEn) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == access_way) begin
                        age[access_set][w] <= '0;
                    end else if (age[access_set][w] < accessAge) begin
                        age[access_set][w] <= age[access_set][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Victim selection: lowest-index invalid eligible way, else oldest eligible way
    always_comb begin
        victimWay    = '0;
        victimNone   = 1'b1;
        foundInvalid = 1'b0;
        bestAge      = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (eligQ[w] && !reqValidQ[w] && !foundInvalid) begin
                victimWay    = WAY_W'(w);
                victimNone   = 1'b0;
                foundInvalid = 1'b1;
            end
        end
        if (!foundInvalid) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (eligQ[w] && (victimNone || (age[reqSetQ][w] > bestAge))) begin
                    victimWay  = WAY_W'(w);
                    bestAge    = age[reqSetQ][w];
                    victimNone = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lru_age_eviction_engine.sv
// Testbench for lru_age_eviction_engine (NUM_WAYS=4, NUM_SETS=4).
// Reference model tracks a last-use timestamp per way; the LRU way is the one with the
// oldest timestamp. Build with LRU_LOCK_EN defined to also exercise lock_mask / rsp_none.
`timescale 1ns/1ps
module tb_lru_age_eviction_engine;

    localparam int NW = 4;
    localparam int NS = 4;
    localparam int WW = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_busy;
    logic          access_valid = 1'b0;
    logic [SW-1:0] access_set = '0;
    logic [WW-1:0] access_way = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_set = '0;
    logic [NW-1:0] req_way_valid = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [WW-1:0] rsp_way;
    logic          rsp_none;
`ifdef LRU_LOCK_EN
    logic [NW-1:0] lock_mask = '0;
`endif

    always #5 clk = ~clk;

    lru_age_eviction_engine #(
        .NUM_WAYS(NW),
        .NUM_SETS(NS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_busy(init_busy),
        .access_valid(access_valid),
        .access_set(access_set),
        .access_way(access_way),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_set(req_set),
        .req_way_valid(req_way_valid),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_way(rsp_way),
        .rsp_none(rsp_none)
`ifdef LRU_LOCK_EN
        ,
        .lock_mask(lock_mask)
`endif
    );

    int     assertCount = 0;
    int     failCount = 0;
    longint ts [NS][NW];
    longint nowTs = 0;
    bit     inInit = 1'b1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference init: way w has age w, i.e. it was used w steps before way 0
    task automatic modelInit();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                ts[s][w] = -longint'(w);
        nowTs = 0;
    endtask

    function automatic void refVictim(input int s, input logic [NW-1:0] vld, input logic [NW-1:0] lck,
                                      output int way, output bit none);
        longint oldest;
        way = 0;
        none = 1'b1;
        oldest = 0;
        for (int w = 0; w < NW; w++) begin
            if (!lck[w] && !vld[w]) begin
                way = w;
                none = 1'b0;
                return;
            end
        end
        for (int w = 0; w < NW; w++) begin
            if (!lck[w] && (none || ts[s][w] < oldest)) begin
                oldest = ts[s][w];
                way = w;
                none = 1'b0;
            end
        end
    endfunction

    // One clock: the model sees the access driven across this edge, outputs sampled 1ns later
    task automatic tick();
        @(posedge clk);
        if (access_valid && !inInit && !reset) begin
            nowTs++;
            ts[access_set][access_way] = nowTs;
        end
        #1;
    endtask

    task automatic randAccess(input int mode, input int s);
        if (mode == 0) begin
            access_valid = 1'b0;
        end else if (mode == 1) begin
            access_valid = 1'b1;
            access_set = SW'(s);
            access_way = WW'($urandom_range(0, NW - 1));
        end else begin
            access_valid = 1'($urandom_range(0, 1));
            access_set = SW'($urandom_range(0, NS - 1));
            access_way = WW'($urandom_range(0, NW - 1));
        end
    endtask

    task automatic doAccess(input int s, input int w);
        access_valid = 1'b1;
        access_set = SW'(s);
        access_way = WW'(w);
        tick();
        access_valid = 1'b0;
    endtask

    task automatic initPhase();
        for (int i = 0; i < NS; i++) begin
            checkVal("initBusy", 32'(init_busy), 1);
            checkVal("initReqReady", 32'(req_ready), 0);
            randAccess(2, 0);
            tick();
        end
        access_valid = 1'b0;
        inInit = 1'b0;
        checkVal("initDoneBusy", 32'(init_busy), 0);
        checkVal("initDoneReady", 32'(req_ready), 1);
    endtask

    task automatic doReq(input int s, input logic [NW-1:0] vld, input logic [NW-1:0] lck,
                         input int accWay, input int accMode, input int hold);
        int waitCnt;
        int expWay;
        bit expNone;
        waitCnt = 0;
        access_valid = 1'b0;
        while (!req_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkVal("reqReady", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_set = SW'(s);
        req_way_valid = vld;
`ifdef LRU_LOCK_EN
        lock_mask = lck;
`endif
        access_valid = (accWay >= 0);
        access_set = SW'(s);
        access_way = WW'((accWay < 0) ? 0 : accWay);
        tick();
        refVictim(s, vld, lck, expWay, expNone);
        req_valid = 1'b0;
        checkVal("lookupReady", 32'(req_ready), 0);
        checkVal("lookupRspValid", 32'(rsp_valid), 0);
        randAccess(accMode, s);
        tick();
        checkVal("rspValid", 32'(rsp_valid), 1);
        checkVal("rspWay", 32'(rsp_way), 32'(expWay));
        checkVal("rspNone", 32'(rsp_none), 32'(expNone));
        for (int h = 0; h < hold; h++) begin
            randAccess(accMode, s);
            tick();
            checkVal("holdValid", 32'(rsp_valid), 1);
            checkVal("holdWay", 32'(rsp_way), 32'(expWay));
            checkVal("holdReady", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        randAccess(accMode, s);
        tick();
        checkVal("rspDoneValid", 32'(rsp_valid), 0);
        checkVal("idleReady", 32'(req_ready), 1);
        rsp_ready = 1'b0;
        access_valid = 1'b0;
    endtask

    task automatic resetMidRequest(input bit inResp);
        req_valid = 1'b1;
        req_set = SW'($urandom_range(0, NS - 1));
        req_way_valid = '1;
        tick();
        req_valid = 1'b0;
        if (inResp) begin
            tick();
            checkVal("preResetRspValid", 32'(rsp_valid), 1);
        end
        reset = 1'b1;
        tick();
        checkVal("resetRspValid", 32'(rsp_valid), 0);
        checkVal("resetInitBusy", 32'(init_busy), 1);
        checkVal("resetReqReady", 32'(req_ready), 0);
        reset = 1'b0;
        modelInit();
        inInit = 1'b1;
        initPhase();
        for (int s = 0; s < NS; s++) doReq(s, '1, '0, -1, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        modelInit();
        reset = 1'b1;
        tick();
        tick();
        checkVal("rstInitBusy", 32'(init_busy), 1);
        checkVal("rstReqReady", 32'(req_ready), 0);
        checkVal("rstRspValid", 32'(rsp_valid), 0);
        checkVal("rstRspWay", 32'(rsp_way), 0);
        checkVal("rstRspNone", 32'(rsp_none), 0);
        reset = 1'b0;
        inInit = 1'b1;
        initPhase();

        doReq(2, 4'hF, '0, -1, 0, 0);

        doAccess(1, 3);
        doAccess(1, 2);
        doAccess(1, 1);
        doReq(1, 4'hF, '0, -1, 0, 0);
        doAccess(1, 0);
        doReq(1, 4'hF, '0, -1, 0, 0);

        doReq(0, 4'b1010, '0, -1, 0, 0);
        doReq(0, 4'b1011, '0, -1, 0, 0);

        doReq(0, 4'hF, '0, 3, 1, 5);

`ifdef LRU_LOCK_EN
        doReq(3, 4'hF, 4'b1000, -1, 0, 0);
        doReq(3, 4'hF, 4'hF, -1, 0, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            int s;
            int accW;
            logic [NW-1:0] vld;
            logic [NW-1:0] lck;
            s = $urandom_range(0, NS - 1);
            vld = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
            lck = '0;
`ifdef LRU_LOCK_EN
            if ($urandom_range(0, 2) == 0) lck = NW'($urandom);
`endif
            accW = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NW - 1)) : -1;
            doReq(s, vld, lck, accW, 2, $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) begin
                randAccess(2, 0);
                tick();
            end
            access_valid = 1'b0;
        end

        resetMidRequest(1'b0);
        resetMidRequest(1'b1);

        for (int i = 0; i < 40; i++) begin
            doReq($urandom_range(0, NS - 1), '1, '0, -1, 2, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
